// File: rtl/bcd6_to_bin_pkg.sv
// Shared types, default sizes and digit helper for the BCD-to-binary decoder.
package bcd6_to_bin_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } convState_t;

   localparam int DIGITS_DEF = 6;
   localparam int BIN_W_DEF  = 20;

   // Widest packed BCD word the digit helper can index into
   localparam int MAX_DIGITS = 16;
   localparam int MAX_WORD_W = 4 * MAX_DIGITS;

   // Returns BCD digit k of a packed word; digit 0 sits in bits [3:0]
   function automatic logic [3:0] digit_at(input logic [MAX_WORD_W-1:0] word, input int k);
      return word[4*k +: 4];
   endfunction

endpackage

// File: rtl/bcd6_to_bin_if.sv
// Valid/ready bus between a BCD source, the decoder and the binary consumer.
interface bcd6_to_bin_if #(
   parameter int DIGITS = 6,
   parameter int BIN_W  = 20
);
   logic                  IN_VALID;
   logic                  IN_READY;
   logic [4*DIGITS-1:0]   BCD_IN;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [BIN_W-1:0]      BIN_OUT;
   logic                  ERR;

   // Source/consumer side: offers words, accepts results
   modport master (
      output IN_VALID, BCD_IN, OUT_READY,
      input  IN_READY, OUT_VALID, BIN_OUT, ERR
   );

   // Decoder side
   modport slave (
      input  IN_VALID, BCD_IN, OUT_READY,
      output IN_READY, OUT_VALID, BIN_OUT, ERR
   );
endinterface

// File: rtl/bcd6_to_bin_mac10.sv
// Multiply-by-ten-and-add step shared by every digit of a conversion.
module bcd_mac10 #(
   parameter int BIN_W = 20
) (
   input  logic [BIN_W-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [BIN_W-1:0] o_accNext,
   output logic             o_digitBad
);

   logic [BIN_W-1:0] w_acc8;
   logic [BIN_W-1:0] w_acc2;

   // acc*10 built from two shifts so no multiplier is inferred
   always_comb begin
      w_acc8     = i_acc << 3;
      w_acc2     = i_acc << 1;
      o_accNext  = w_acc8 + w_acc2 + BIN_W'(i_digit);
      o_digitBad = (i_digit > 4'd9);
   end

endmodule

// File: rtl/bcd6_to_bin.sv
// Sequential packed-BCD to binary decoder, one digit per cycle, MSD first.
module bcd6_to_bin
   import bcd6_to_bin_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic            CLK,
   input  logic            CLR_N,
   bcd6_to_bin_if.slave    bus
);

   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int WORD_W = 4 * DIGITS;

   convState_t             r_state;
   convState_t             w_stateNext;

   logic [WORD_W-1:0]      r_word;
   logic [BIN_W-1:0]       r_acc;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_errFlag;

   logic                   r_inReady;
   logic                   r_outValid;
   logic [BIN_W-1:0]       r_binOut;
   logic                   r_errOut;

   logic                   w_inReadyNext;
   logic                   w_outValidNext;
   logic [BIN_W-1:0]       w_binNext;
   logic                   w_errNext;

   logic                   w_inFire;
   logic                   w_outFire;
   logic                   w_lastDigit;
   logic [MAX_WORD_W-1:0]  w_wordExt;
   logic [3:0]             w_digit;
   logic [BIN_W-1:0]       w_accNext;
   logic                   w_digitBad;
   logic                   w_errAll;

   assign w_inFire    = (r_state == IDLE) && bus.IN_VALID;
   assign w_outFire   = (r_state == DONE) && bus.OUT_READY;
   assign w_lastDigit = (r_idx == '0);
   assign w_wordExt   = MAX_WORD_W'(r_word);
   assign w_digit     = digit_at(w_wordExt, int'(r_idx));
   assign w_errAll    = r_errFlag | w_digitBad;

   bcd_mac10 #(
      .BIN_W      (BIN_W)
   ) u_mac10 (
      .i_acc      (r_acc),
      .i_digit    (w_digit),
      .o_accNext  (w_accNext),
      .o_digitBad (w_digitBad)
   );

   // State register; reset abandons any conversion in flight
   always_ff @(posedge CLK) begin
      if (!CLR_N) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   // Next-state: accept a word, walk DIGITS digits, then wait for the consumer
   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         IDLE:    if (w_inFire)    w_stateNext = CONV;
         CONV:    if (w_lastDigit) w_stateNext = DONE;
         DONE:    if (w_outFire)   w_stateNext = IDLE;
         default:                  w_stateNext = IDLE;
      endcase
   end

   // Next values of the registered handshake and result outputs
   always_comb begin
      w_inReadyNext  = r_inReady;
      w_outValidNext = r_outValid;
      w_binNext      = r_binOut;
      w_errNext      = r_errOut;
      unique case (r_state)
         IDLE: begin
            if (w_inFire) w_inReadyNext = 1'b0;
         end
         CONV: begin
            if (w_lastDigit) begin
               w_outValidNext = 1'b1;
               w_binNext      = w_errAll ? '0 : w_accNext;
               w_errNext      = w_errAll;
            end
         end
         DONE: begin
            if (w_outFire) begin
               w_outValidNext = 1'b0;
               w_inReadyNext  = 1'b1;
            end
         end
         default: begin
            w_inReadyNext  = 1'b1;
            w_outValidNext = 1'b0;
         end
      endcase
   end

   // Output registers so nothing reaches the bus combinationally from inputs
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_binOut   <= '0;
         r_errOut   <= 1'b0;
      end else begin
         r_inReady  <= w_inReadyNext;
         r_outValid <= w_outValidNext;
         r_binOut   <= w_binNext;
         r_errOut   <= w_errNext;
      end
   end

   // Capture the word on transfer, then accumulate one digit per CONV cycle
   always_ff @(posedge CLK) begin
      if (!CLR_N) begin
         r_word    <= '0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_errFlag <= 1'b0;
      end else if (w_inFire) begin
         r_word    <= bus.BCD_IN;
         r_acc     <= '0;
         r_idx     <= IDX_W'(DIGITS - 1);
         r_errFlag <= 1'b0;
      end else if (r_state == CONV) begin
         r_acc     <= w_accNext;
         r_errFlag <= w_errAll;
         if (!w_lastDigit) r_idx <= r_idx - IDX_W'(1);
      end
   end

   assign bus.IN_READY  = r_inReady;
   assign bus.OUT_VALID = r_outValid;
   assign bus.BIN_OUT   = r_binOut;
   assign bus.ERR       = r_errOut;

endmodule

// File: tb/tb_bcd6_to_bin.sv
// Self-checking bench for bcd6_to_bin using a result scoreboard queue.
module tb_bcd6_to_bin;

   localparam int DIGITS = 6;
   localparam int BIN_W  = 20;

   logic CLK;
   logic CLR_N;

   int checks   = 0;
   int failures = 0;

   logic [BIN_W:0] sbQueue[$];

   bcd6_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd6_to_bin #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) dut (
      .CLK    (CLK),
      .CLR_N  (CLR_N),
      .bus    (bus.slave)
   );

   // 10 ns clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop in case something wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference decode: {err, bin}
   function automatic logic [BIN_W:0] bcdModel(input logic [23:0] w);
      int acc = 0;
      bit e = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         int d;
         d = int'(w[4*k +: 4]);
         if (d > 9) e = 1'b1;
         acc = acc * 10 + d;
      end
      return {e, (e ? 20'd0 : 20'(acc))};
   endfunction

   task automatic stepCycle();
      @(posedge CLK);
      #1;
   endtask

   // Offer a word until it is taken; optionally record its expected result
   task automatic applyStimulus(input logic [23:0] word, input bit push, output bit ok);
      ok = 1'b0;
      bus.BCD_IN   = word;
      bus.IN_VALID = 1'b1;
      for (int n = 0; n < 20; n++) begin
         if (bus.IN_READY) begin
            stepCycle();
            ok = 1'b1;
            break;
         end
         stepCycle();
      end
      bus.IN_VALID = 1'b0;
      if (ok && push) sbQueue.push_back(bcdModel(word));
   endtask

   // Wait for OUT_VALID, reporting edges since the transfer
   task automatic checkOutput(output logic [BIN_W-1:0] bin, output logic err,
                              output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int n = 0; n < 20; n++) begin
         stepCycle();
         lat++;
         if (bus.OUT_VALID) begin
            ok = 1'b1;
            break;
         end
      end
      bin = bus.BIN_OUT;
      err = bus.ERR;
   endtask

   task automatic acceptResult();
      bus.OUT_READY = 1'b1;
      stepCycle();
      bus.OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      CLR_N = 1'b0;
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.BCD_IN    = '0;
      repeat (3) stepCycle();
      CLR_N = 1'b1;
      stepCycle();
      checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.IN_READY); end
      checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.OUT_VALID); end
      checks++; if (bus.BIN_OUT !== 20'd0) begin failures++; $display("[TB] FAIL reset_bin got=%0d exp=0", bus.BIN_OUT); end
      checks++; if (bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.ERR); end
   endtask

   task automatic test_values();
      logic [23:0] words[4] = '{24'h000000, 24'h999999, 24'h123456, 24'h000507};
      logic [BIN_W-1:0] bin;
      logic err;
      logic [BIN_W:0] exp;
      int lat;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(words[i], 1'b1, ok);
         checks++; if (!ok) begin failures++; $display("[TB] FAIL value_xfer word=%h got=timeout exp=transfer", words[i]); end
         checkOutput(bin, err, lat, ok);
         checks++; if (!ok) begin failures++; $display("[TB] FAIL value_out word=%h got=timeout exp=out_valid", words[i]); end
         exp = (sbQueue.size() > 0) ? sbQueue.pop_front() : '1;
         checks++; if (lat !== DIGITS) begin failures++; $display("[TB] FAIL value_latency word=%h got=%0d exp=%0d", words[i], lat, DIGITS); end
         checks++; if (bin !== exp[BIN_W-1:0]) begin failures++; $display("[TB] FAIL value_bin word=%h got=%0d exp=%0d", words[i], bin, exp[BIN_W-1:0]); end
         checks++; if (err !== exp[BIN_W]) begin failures++; $display("[TB] FAIL value_err word=%h got=%b exp=%b", words[i], err, exp[BIN_W]); end
         acceptResult();
         checks++; if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL value_release word=%h got=rdy%b/vld%b exp=rdy1/vld0", words[i], bus.IN_READY, bus.OUT_VALID); end
      end
      checks++; if (bcdModel(24'h999999) !== {1'b0, 20'hF423F}) begin failures++; $display("[TB] FAIL model_999999 got=%h exp=0F423F", bcdModel(24'h999999)); end
   endtask

   task automatic test_error();
      logic [23:0] words[2] = '{24'h12A456, 24'h000010};
      logic [BIN_W:0] fixedExp[2] = '{{1'b1, 20'd0}, {1'b0, 20'd10}};
      logic [BIN_W-1:0] bin;
      logic err;
      logic [BIN_W:0] exp;
      int lat;
      bit ok;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(words[i], 1'b1, ok);
         checkOutput(bin, err, lat, ok);
         checks++; if (!ok) begin failures++; $display("[TB] FAIL err_out word=%h got=timeout exp=out_valid", words[i]); end
         exp = (sbQueue.size() > 0) ? sbQueue.pop_front() : '1;
         checks++; if ({err, bin} !== exp || exp !== fixedExp[i]) begin failures++; $display("[TB] FAIL err_result word=%h got=err%b/%0d exp=err%b/%0d", words[i], err, bin, fixedExp[i][BIN_W], fixedExp[i][BIN_W-1:0]); end
         acceptResult();
      end
   endtask

   task automatic test_backpressure();
      logic [BIN_W-1:0] bin;
      logic err;
      logic [BIN_W:0] exp;
      int lat;
      int extra;
      bit ok;
      applyStimulus(24'h000042, 1'b1, ok);
      checkOutput(bin, err, lat, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_out got=timeout exp=out_valid"); end
      exp = (sbQueue.size() > 0) ? sbQueue.pop_front() : '1;
      bus.IN_VALID = 1'b1;
      bus.BCD_IN   = 24'h777777;
      for (int c = 0; c < 5; c++) begin
         stepCycle();
         checks++; if (bus.OUT_VALID !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.OUT_VALID); end
         checks++; if (bus.BIN_OUT !== exp[BIN_W-1:0]) begin failures++; $display("[TB] FAIL bp_bin cyc=%0d got=%0d exp=%0d", c, bus.BIN_OUT, exp[BIN_W-1:0]); end
         checks++; if (bus.ERR !== exp[BIN_W]) begin failures++; $display("[TB] FAIL bp_err cyc=%0d got=%b exp=%b", c, bus.ERR, exp[BIN_W]); end
         checks++; if (bus.IN_READY !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.IN_READY); end
      end
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b1;
      stepCycle();
      checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL bp_consume got=%b exp=0", bus.OUT_VALID); end
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         stepCycle();
         if (bus.OUT_VALID) extra++;
      end
      bus.OUT_READY = 1'b0;
      checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL bp_single got=%0d extra_results exp=0", extra); end
   endtask

   task automatic test_reset_mid_conv();
      int stale;
      bit ok;
      applyStimulus(24'h654321, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_xfer got=timeout exp=transfer"); end
      stepCycle();
      stepCycle();
      CLR_N = 1'b0;
      stepCycle();
      CLR_N = 1'b1;
      checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_in_ready got=%b exp=1", bus.IN_READY); end
      checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_out_valid got=%b exp=0", bus.OUT_VALID); end
      checks++; if (bus.BIN_OUT !== 20'd0 || bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_result got=err%b/%0d exp=err0/0", bus.ERR, bus.BIN_OUT); end
      stale = 0;
      bus.OUT_READY = 1'b1;
      for (int c = 0; c < 12; c++) begin
         stepCycle();
         if (bus.OUT_VALID) stale++;
      end
      bus.OUT_READY = 1'b0;
      checks++; if (stale !== 0) begin failures++; $display("[TB] FAIL rst_mid_stale got=%0d exp=0", stale); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] words[3] = '{24'h000001, 24'h000002, 24'h999998};
      logic [BIN_W-1:0] fixedBin[3] = '{20'd1, 20'd2, 20'd999998};
      int xferCyc[3] = '{0, 0, 0};
      logic [BIN_W:0] exp;
      int k = 0;
      int got = 0;
      int cyc = 0;
      bit willXfer;
      bus.OUT_READY = 1'b1;
      bus.IN_VALID  = 1'b1;
      bus.BCD_IN    = words[0];
      for (int n = 0; n < 80 && got < 3; n++) begin
         willXfer = bus.IN_READY && bus.IN_VALID;
         stepCycle();
         cyc++;
         if (willXfer) begin
            xferCyc[k] = cyc;
            sbQueue.push_back(bcdModel(words[k]));
            k++;
            if (k < 3) bus.BCD_IN = words[k];
            else       bus.IN_VALID = 1'b0;
         end
         if (bus.OUT_VALID) begin
            exp = (sbQueue.size() > 0) ? sbQueue.pop_front() : '1;
            checks++; if (bus.BIN_OUT !== exp[BIN_W-1:0] || bus.BIN_OUT !== fixedBin[got] || bus.ERR !== 1'b0) begin failures++; $display("[TB] FAIL b2b_result idx=%0d got=err%b/%0d exp=err0/%0d", got, bus.ERR, bus.BIN_OUT, fixedBin[got]); end
            got++;
         end
      end
      stepCycle();
      bus.OUT_READY = 1'b0;
      bus.IN_VALID  = 1'b0;
      checks++; if (got !== 3) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=3", got); end
      checks++; if (xferCyc[1] - xferCyc[0] !== DIGITS + 2) begin failures++; $display("[TB] FAIL b2b_spacing01 got=%0d exp=%0d", xferCyc[1] - xferCyc[0], DIGITS + 2); end
      checks++; if (xferCyc[2] - xferCyc[1] !== DIGITS + 2) begin failures++; $display("[TB] FAIL b2b_spacing12 got=%0d exp=%0d", xferCyc[2] - xferCyc[1], DIGITS + 2); end
      checks++; if (sbQueue.size() !== 0) begin failures++; $display("[TB] FAIL b2b_leftover got=%0d exp=0", sbQueue.size()); end
   endtask

   initial begin
      $display("[TB] starting bcd6_to_bin bench");
      test_reset();
      test_values();
      test_error();
      test_backpressure();
      test_reset_mid_conv();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
